// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared opcodes, access-size and state encodings, and
//               instruction field positions for the load/store stage.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package lsu_pkg;

    // Major opcodes the stage distinguishes
    localparam logic [6:0] c_opc_load  = 7'b0000011;
    localparam logic [6:0] c_opc_store = 7'b0100011;
    localparam logic [6:0] c_opc_jal   = 7'b1101111;
    localparam logic [6:0] c_opc_jalr  = 7'b1100111;
    localparam logic [6:0] c_opc_auipc = 7'b0010111;

    // Instruction field positions
    localparam int c_opcode_msb     = 6;
    localparam int c_funct3_lsb     = 12;
    localparam int c_funct3_uns_bit = 14;

    // Access size taken from funct3[1:0]
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    // Stage state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Extract the access size from an instruction word
    function automatic size_e f_size(input logic [31:0] instr);
        return size_e'(instr[c_funct3_lsb+1:c_funct3_lsb]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : EX->MEM hand-off, memory bus and MEM->WB hand-off signals of
//               the load/store stage. The slave modport is the stage's view,
//               the master modport is the surrounding pipeline/memory view.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface lsu_if #(
    parameter int XLEN = 32
);
    localparam int BE_W = XLEN / 8;

    // EX -> MEM
    logic              EX_MEM_give_i;
    logic              MEM_EX_get_o;
    logic [31:0]       EX_MEM_instr_i;
    logic [XLEN-1:0]   EX_MEM_result_i;
    logic [XLEN-1:0]   EX_MEM_rs2_i;
    logic [XLEN-1:0]   EX_MEM_pc_i;
    // Memory bus
    logic [XLEN-1:0]   MEM_addr_o;
    logic [XLEN-1:0]   MEM_data_o;
    logic [BE_W-1:0]   MEM_be_o;
    logic              MEM_read_o;
    logic              MEM_write_o;
    logic [XLEN-1:0]   MEM_data_i;
    logic              MEM_valid_i;
    // MEM -> WB
    logic              WB_MEM_get_i;
    logic              MEM_WB_give_o;
    logic [31:0]       MEM_WB_instr_o;
    logic [XLEN-1:0]   MEM_WB_data_o;
    logic              MEM_WB_fault_o;

    modport slave (
        input  EX_MEM_give_i, EX_MEM_instr_i, EX_MEM_result_i, EX_MEM_rs2_i, EX_MEM_pc_i,
        input  MEM_data_i, MEM_valid_i, WB_MEM_get_i,
        output MEM_EX_get_o, MEM_addr_o, MEM_data_o, MEM_be_o, MEM_read_o, MEM_write_o,
        output MEM_WB_give_o, MEM_WB_instr_o, MEM_WB_data_o, MEM_WB_fault_o
    );

    modport master (
        output EX_MEM_give_i, EX_MEM_instr_i, EX_MEM_result_i, EX_MEM_rs2_i, EX_MEM_pc_i,
        output MEM_data_i, MEM_valid_i, WB_MEM_get_i,
        input  MEM_EX_get_o, MEM_addr_o, MEM_data_o, MEM_be_o, MEM_read_o, MEM_write_o,
        input  MEM_WB_give_o, MEM_WB_instr_o, MEM_WB_data_o, MEM_WB_fault_o
    );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane logic. Store side: byte strobes,
//               lane-shifted data, effective size/offset and fault flag.
//               Load side: lane extraction and sign/zero extension.
//               Macro LSU_MISALIGN_FAULT_EN: misaligned or illegal-size
//               accesses raise the fault flag; otherwise the offset is forced
//               to size alignment and an illegal size is handled as a word.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  size_e             i_st_size,
    input  logic [OFF_W-1:0]  i_st_off,
    input  logic [XLEN-1:0]   i_st_data,
    output logic [BE_W-1:0]   o_st_be,
    output logic [XLEN-1:0]   o_st_lane_data,
    output logic [OFF_W-1:0]  o_st_eff_off,
    output size_e             o_st_eff_size,
    output logic              o_st_fault,
    input  size_e             i_ld_size,
    input  logic [OFF_W-1:0]  i_ld_off,
    input  logic              i_ld_unsigned,
    input  logic [XLEN-1:0]   i_ld_raw,
    output logic [XLEN-1:0]   o_ld_value
);

    logic              w_illegal;
    size_e             w_eff_size;
    logic [OFF_W-1:0]  w_low_mask;
    logic [BE_W-1:0]   w_byte_mask;
    logic [OFF_W-1:0]  w_eff_off;
    logic [XLEN-1:0]   w_ld_shifted;
    logic [XLEN-1:0]   w_ext_w;

    // A doubleword only exists on the 64-bit datapath
    assign w_illegal  = (i_st_size == SIZE_D) && (XLEN == 32);
    assign w_eff_size = w_illegal ? SIZE_W : i_st_size;

    // Offset bits that must be zero for an aligned access, and the strobe
    // pattern of the access before lane shifting
    always_comb begin
        w_low_mask  = '0;
        w_byte_mask = '0;
        for (int i = 0; i < OFF_W; i++) begin
            w_low_mask[i] = (i < int'(w_eff_size));
        end
        for (int i = 0; i < BE_W; i++) begin
            w_byte_mask[i] = (i < (1 << int'(w_eff_size)));
        end
    end

`ifdef LSU_MISALIGN_FAULT_EN
    assign w_eff_off  = i_st_off;
    assign o_st_fault = w_illegal || ((i_st_off & w_low_mask) != '0);
`else
    assign w_eff_off  = i_st_off & ~w_low_mask;
    assign o_st_fault = 1'b0;
`endif

    assign o_st_eff_off   = w_eff_off;
    assign o_st_eff_size  = w_eff_size;
    assign o_st_be        = w_byte_mask << w_eff_off;
    assign o_st_lane_data = i_st_data << {w_eff_off, 3'b000};

    // Bring the addressed lane down to bit 0 of the load result
    assign w_ld_shifted = i_ld_raw >> {i_ld_off, 3'b000};

    generate
        if (XLEN > 32) begin : g_word_ext
            assign w_ext_w = {{(XLEN-32){~i_ld_unsigned & w_ld_shifted[31]}}, w_ld_shifted[31:0]};
        end else begin : g_word_full
            assign w_ext_w = w_ld_shifted;
        end
    endgenerate

    // Extend the extracted lane to the full register width
    always_comb begin
        o_ld_value = w_ld_shifted;
        case (i_ld_size)
            SIZE_B:  o_ld_value = {{(XLEN-8){~i_ld_unsigned & w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            SIZE_H:  o_ld_value = {{(XLEN-16){~i_ld_unsigned & w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            SIZE_W:  o_ld_value = w_ext_w;
            default: o_ld_value = w_ld_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage
// Description : Load/store pipeline stage between EX and WB. Issues one
//               memory request per load/store, extracts and extends load
//               data, and passes non-memory results straight through with a
//               one-cycle hand-off. Datapath width XLEN = 32 or 64.
//               Macro LSU_MISALIGN_FAULT_EN enables misalignment faults.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic  clk,
    input  logic  resetn_i,
    lsu_if.slave  bus
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    state_e            r_state;
    logic [31:0]       r_instr;
    logic [XLEN-1:0]   r_mem_addr;
    logic [XLEN-1:0]   r_mem_data;
    logic [BE_W-1:0]   r_mem_be;
    logic              r_read;
    logic              r_write;
    size_e             r_ld_size;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_wb_fault;
    logic              r_give;

    logic [6:0]        w_opcode;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_is_link;
    logic              w_get;
    logic              w_ex_xfer;
    logic              w_wb_xfer;
    size_e             w_ex_size;
    logic [BE_W-1:0]   w_st_be;
    logic [XLEN-1:0]   w_st_data;
    logic [OFF_W-1:0]  w_st_off;
    size_e             w_st_size;
    logic              w_st_fault;
    logic [XLEN-1:0]   w_ld_value;

    assign w_opcode   = bus.EX_MEM_instr_i[c_opcode_msb:0];
    assign w_is_load  = (w_opcode == c_opc_load);
    assign w_is_store = (w_opcode == c_opc_store);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_is_link  = (w_opcode == c_opc_jal) || (w_opcode == c_opc_jalr);
    assign w_ex_size  = f_size(bus.EX_MEM_instr_i);

    // Accept from EX when empty, or when the held result leaves this cycle;
    // held low while reset is asserted so every output reads 0 in reset
    assign w_get     = resetn_i && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_RESP) && bus.WB_MEM_get_i));
    assign w_ex_xfer = bus.EX_MEM_give_i && w_get;
    assign w_wb_xfer = r_give && bus.WB_MEM_get_i;

    // Store lanes and fault from the incoming instruction; load extraction
    // from the captured request and the returning bus word
    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_st_size      (w_ex_size),
        .i_st_off       (bus.EX_MEM_result_i[OFF_W-1:0]),
        .i_st_data      (bus.EX_MEM_rs2_i),
        .o_st_be        (w_st_be),
        .o_st_lane_data (w_st_data),
        .o_st_eff_off   (w_st_off),
        .o_st_eff_size  (w_st_size),
        .o_st_fault     (w_st_fault),
        .i_ld_size      (r_ld_size),
        .i_ld_off       (r_mem_addr[OFF_W-1:0]),
        .i_ld_unsigned  (r_instr[c_funct3_uns_bit]),
        .i_ld_raw       (bus.MEM_data_i),
        .o_ld_value     (w_ld_value)
    );

    // Stage state machine: capture from EX, run the memory request, hold result for WB
    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            r_state    <= ST_IDLE;
            r_instr    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_be   <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_ld_size  <= SIZE_B;
            r_wb_data  <= '0;
            r_wb_fault <= 1'b0;
            r_give     <= 1'b0;
        end else if (w_ex_xfer) begin
            // New instruction, from IDLE or overlapping the WB hand-off
            r_instr    <= bus.EX_MEM_instr_i;
            r_ld_size  <= w_st_size;
            r_wb_fault <= w_is_mem && w_st_fault;
            if (w_is_mem && !w_st_fault) begin
                r_state    <= ST_REQ;
                r_give     <= 1'b0;
                r_read     <= w_is_load;
                r_write    <= w_is_store;
                r_mem_addr <= {bus.EX_MEM_result_i[XLEN-1:OFF_W], w_st_off};
                r_mem_be   <= w_is_store ? w_st_be : '0;
                r_mem_data <= w_is_store ? w_st_data : '0;
                r_wb_data  <= '0;
            end else begin
                // Non-memory ops and faulting accesses report the ALU result
                // (the address, for a fault); links report the return address
                r_state    <= ST_RESP;
                r_give     <= 1'b1;
                r_read     <= 1'b0;
                r_write    <= 1'b0;
                r_wb_data  <= w_is_link ? (bus.EX_MEM_pc_i + XLEN'(4)) : bus.EX_MEM_result_i;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (bus.MEM_valid_i) begin
                        r_state    <= ST_RESP;
                        r_give     <= 1'b1;
                        r_read     <= 1'b0;
                        r_write    <= 1'b0;
                        r_mem_be   <= '0;
                        r_mem_data <= '0;
                        r_wb_data  <= r_read ? w_ld_value : '0;
                    end
                end
                ST_RESP: begin
                    if (w_wb_xfer) begin
                        r_state <= ST_IDLE;
                        r_give  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign bus.MEM_EX_get_o   = w_get;
    assign bus.MEM_addr_o     = r_mem_addr;
    assign bus.MEM_data_o     = r_mem_data;
    assign bus.MEM_be_o       = r_mem_be;
    assign bus.MEM_read_o     = r_read;
    assign bus.MEM_write_o    = r_write;
    assign bus.MEM_WB_give_o  = r_give;
    assign bus.MEM_WB_instr_o = r_instr;
    assign bus.MEM_WB_data_o  = r_wb_data;
    assign bus.MEM_WB_fault_o = r_wb_fault;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_stage
// Description : Directed self-checking bench for lsu_stage at XLEN=32 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    lsu_if #(.XLEN(32)) if32 ();
    lsu_if #(.XLEN(64)) if64 ();

    lsu_stage #(.XLEN(32)) u_dut32 (.clk(clk), .resetn_i(resetn), .bus(if32));
    lsu_stage #(.XLEN(64)) u_dut64 (.clk(clk), .resetn_i(resetn), .bus(if64));

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
        return {17'd0, f3, 5'd0, opc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer32(input logic [31:0] instr, input logic [31:0] res,
                           input logic [31:0] rs2, input logic [31:0] pc);
        if32.EX_MEM_instr_i  = instr;
        if32.EX_MEM_result_i = res;
        if32.EX_MEM_rs2_i    = rs2;
        if32.EX_MEM_pc_i     = pc;
        if32.EX_MEM_give_i   = 1'b1;
    endtask

    task automatic offer64(input logic [31:0] instr, input logic [63:0] res,
                           input logic [63:0] rs2, input logic [63:0] pc);
        if64.EX_MEM_instr_i  = instr;
        if64.EX_MEM_result_i = res;
        if64.EX_MEM_rs2_i    = rs2;
        if64.EX_MEM_pc_i     = pc;
        if64.EX_MEM_give_i   = 1'b1;
    endtask

    task automatic test_reset();
        if32.EX_MEM_give_i = 0; if32.EX_MEM_instr_i = 0; if32.EX_MEM_result_i = 0;
        if32.EX_MEM_rs2_i = 0; if32.EX_MEM_pc_i = 0; if32.MEM_data_i = 0;
        if32.MEM_valid_i = 0; if32.WB_MEM_get_i = 0;
        if64.EX_MEM_give_i = 0; if64.EX_MEM_instr_i = 0; if64.EX_MEM_result_i = 0;
        if64.EX_MEM_rs2_i = 0; if64.EX_MEM_pc_i = 0; if64.MEM_data_i = 0;
        if64.MEM_valid_i = 0; if64.WB_MEM_get_i = 0;
        resetn = 1'b0;
        step(); step();
        vectors++; if (if32.MEM_EX_get_o !== 1'b0) begin miscompares++; $display("FAIL rst_get: got %b expected 0", if32.MEM_EX_get_o); end
        vectors++; if ({if32.MEM_WB_give_o, if32.MEM_read_o, if32.MEM_write_o, if32.MEM_WB_fault_o} !== 4'b0000) begin
            miscompares++; $display("FAIL rst_strobes: got %b expected 0000", {if32.MEM_WB_give_o, if32.MEM_read_o, if32.MEM_write_o, if32.MEM_WB_fault_o}); end
        vectors++; if ({if32.MEM_be_o, if32.MEM_WB_data_o, if32.MEM_data_o} !== 68'd0) begin
            miscompares++; $display("FAIL rst_data: got %h expected 0", {if32.MEM_be_o, if32.MEM_WB_data_o, if32.MEM_data_o}); end
        vectors++; if (if64.MEM_WB_give_o !== 1'b0) begin miscompares++; $display("FAIL rst_give64: got %b expected 0", if64.MEM_WB_give_o); end
        resetn = 1'b1;
        step();
        vectors++; if (if32.MEM_EX_get_o !== 1'b1) begin miscompares++; $display("FAIL idle_get32: got %b expected 1", if32.MEM_EX_get_o); end
        vectors++; if (if64.MEM_EX_get_o !== 1'b1) begin miscompares++; $display("FAIL idle_get64: got %b expected 1", if64.MEM_EX_get_o); end
    endtask

    task automatic test_sb();
        offer32(mk(3'b000, OPC_STORE), 32'h0000_0103, 32'h1234_56AB, 32'h200);
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if ({if32.MEM_write_o, if32.MEM_read_o} !== 2'b10) begin miscompares++; $display("FAIL sb_strobe: got %b expected 10", {if32.MEM_write_o, if32.MEM_read_o}); end
        vectors++; if (if32.MEM_be_o !== 4'b1000) begin miscompares++; $display("FAIL sb_be: got %b expected 1000", if32.MEM_be_o); end
        vectors++; if (if32.MEM_data_o !== 32'hAB00_0000) begin miscompares++; $display("FAIL sb_data: got %h expected ab000000", if32.MEM_data_o); end
        vectors++; if (if32.MEM_addr_o !== 32'h103) begin miscompares++; $display("FAIL sb_addr: got %h expected 00000103", if32.MEM_addr_o); end
        vectors++; if (if32.MEM_EX_get_o !== 1'b0) begin miscompares++; $display("FAIL sb_get_req: got %b expected 0", if32.MEM_EX_get_o); end
        step();
        vectors++; if ({if32.MEM_write_o, if32.MEM_be_o, if32.MEM_WB_give_o} !== 6'b1_1000_0) begin
            miscompares++; $display("FAIL sb_hold: got %b expected 110000", {if32.MEM_write_o, if32.MEM_be_o, if32.MEM_WB_give_o}); end
        if32.MEM_valid_i = 1;
        step();
        if32.MEM_valid_i = 0;
        vectors++; if ({if32.MEM_write_o, if32.MEM_WB_give_o, if32.MEM_WB_fault_o} !== 3'b010) begin
            miscompares++; $display("FAIL sb_done: got %b expected 010", {if32.MEM_write_o, if32.MEM_WB_give_o, if32.MEM_WB_fault_o}); end
        vectors++; if (if32.MEM_WB_data_o !== 32'd0) begin miscompares++; $display("FAIL sb_wbdata: got %h expected 0", if32.MEM_WB_data_o); end
        vectors++; if (if32.MEM_WB_instr_o !== mk(3'b000, OPC_STORE)) begin miscompares++; $display("FAIL sb_instr: got %h expected %h", if32.MEM_WB_instr_o, mk(3'b000, OPC_STORE)); end
        if32.WB_MEM_get_i = 1;
        step();
        if32.WB_MEM_get_i = 0;
        vectors++; if (if32.MEM_WB_give_o !== 1'b0) begin miscompares++; $display("FAIL sb_retire: got %b expected 0", if32.MEM_WB_give_o); end
    endtask

    task automatic test_lh_lhu();
        offer32(mk(3'b001, OPC_LOAD), 32'h102, 32'h0, 32'h300);
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if ({if32.MEM_read_o, if32.MEM_write_o, if32.MEM_be_o} !== 6'b10_0000) begin
            miscompares++; $display("FAIL lh_req: got %b expected 100000", {if32.MEM_read_o, if32.MEM_write_o, if32.MEM_be_o}); end
        vectors++; if (if32.MEM_addr_o !== 32'h102) begin miscompares++; $display("FAIL lh_addr: got %h expected 00000102", if32.MEM_addr_o); end
        if32.MEM_data_i = 32'h8001_0000; if32.MEM_valid_i = 1;
        step();
        if32.MEM_valid_i = 0;
        vectors++; if (if32.MEM_WB_give_o !== 1'b1) begin miscompares++; $display("FAIL lh_give: got %b expected 1", if32.MEM_WB_give_o); end
        vectors++; if (if32.MEM_WB_data_o !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_data: got %h expected ffff8001", if32.MEM_WB_data_o); end
        // hand off to WB while accepting the LHU in the same cycle
        if32.WB_MEM_get_i = 1;
        offer32(mk(3'b101, OPC_LOAD), 32'h102, 32'h0, 32'h304);
        #1;
        vectors++; if (if32.MEM_EX_get_o !== 1'b1) begin miscompares++; $display("FAIL lhu_get_overlap: got %b expected 1", if32.MEM_EX_get_o); end
        step();
        if32.WB_MEM_get_i = 0; if32.EX_MEM_give_i = 0;
        vectors++; if ({if32.MEM_read_o, if32.MEM_WB_give_o} !== 2'b10) begin miscompares++; $display("FAIL lhu_req: got %b expected 10", {if32.MEM_read_o, if32.MEM_WB_give_o}); end
        if32.MEM_valid_i = 1;
        step();
        if32.MEM_valid_i = 0;
        vectors++; if (if32.MEM_WB_data_o !== 32'h0000_8001) begin miscompares++; $display("FAIL lhu_data: got %h expected 00008001", if32.MEM_WB_data_o); end
        if32.WB_MEM_get_i = 1;
        step();
        if32.WB_MEM_get_i = 0;
    endtask

    task automatic test_xlen64();
        offer64(mk(3'b011, OPC_LOAD), 64'h8, 64'h0, 64'h400);
        step();
        if64.EX_MEM_give_i = 0;
        vectors++; if ({if64.MEM_read_o, if64.MEM_addr_o} !== {1'b1, 64'h8}) begin
            miscompares++; $display("FAIL ld64_req: got %b/%h expected 1/0000000000000008", if64.MEM_read_o, if64.MEM_addr_o); end
        if64.MEM_data_i = 64'h0123_4567_89AB_CDEF; if64.MEM_valid_i = 1;
        step();
        if64.MEM_valid_i = 0;
        vectors++; if (if64.MEM_WB_data_o !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL ld64_data: got %h expected 0123456789abcdef", if64.MEM_WB_data_o); end
        if64.WB_MEM_get_i = 1;
        step();
        if64.WB_MEM_get_i = 0;
        offer64(mk(3'b010, OPC_LOAD), 64'hC, 64'h0, 64'h404);
        step();
        if64.EX_MEM_give_i = 0;
        vectors++; if ({if64.MEM_addr_o, if64.MEM_be_o} !== {64'hC, 8'h00}) begin
            miscompares++; $display("FAIL lw64_req: got %h/%h expected 000000000000000c/00", if64.MEM_addr_o, if64.MEM_be_o); end
        if64.MEM_data_i = 64'h8000_0000_1234_5678; if64.MEM_valid_i = 1;
        step();
        if64.MEM_valid_i = 0;
        vectors++; if (if64.MEM_WB_data_o !== 64'hFFFF_FFFF_8000_0000) begin miscompares++; $display("FAIL lw64_data: got %h expected ffffffff80000000", if64.MEM_WB_data_o); end
        if64.WB_MEM_get_i = 1;
        step();
        if64.WB_MEM_get_i = 0;
        offer64(mk(3'b001, OPC_STORE), 64'h6, 64'hBEEF, 64'h408);
        step();
        if64.EX_MEM_give_i = 0;
        vectors++; if (if64.MEM_be_o !== 8'hC0) begin miscompares++; $display("FAIL sh64_be: got %h expected c0", if64.MEM_be_o); end
        vectors++; if (if64.MEM_data_o !== 64'hBEEF_0000_0000_0000) begin miscompares++; $display("FAIL sh64_data: got %h expected beef000000000000", if64.MEM_data_o); end
        if64.MEM_valid_i = 1;
        step();
        if64.MEM_valid_i = 0; if64.WB_MEM_get_i = 1;
        step();
        if64.WB_MEM_get_i = 0;
    endtask

    task automatic test_back_to_back();
        if32.WB_MEM_get_i = 1;
        for (int i = 0; i < 4; i++) begin
            offer32(mk(3'b000, OPC_OP), 32'h10 * (i + 1), 32'h0, 32'h500);
            #1;
            vectors++; if (if32.MEM_EX_get_o !== 1'b1) begin miscompares++; $display("FAIL b2b_get[%0d]: got %b expected 1", i, if32.MEM_EX_get_o); end
            step();
            vectors++; if ({if32.MEM_WB_give_o, if32.MEM_WB_data_o} !== {1'b1, 32'h10 * (i + 1)}) begin
                miscompares++; $display("FAIL b2b_data[%0d]: got %b/%h expected 1/%h", i, if32.MEM_WB_give_o, if32.MEM_WB_data_o, 32'h10 * (i + 1)); end
        end
        if32.EX_MEM_give_i = 0;
        step();
        if32.WB_MEM_get_i = 0;
        vectors++; if (if32.MEM_WB_give_o !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b expected 0", if32.MEM_WB_give_o); end
    endtask

    task automatic test_wb_stall();
        offer32(mk(3'b000, OPC_OP), 32'h55, 32'h0, 32'h600);
        step();
        offer32(mk(3'b000, OPC_OP), 32'h66, 32'h0, 32'h604);
        for (int k = 0; k < 3; k++) begin
            vectors++; if ({if32.MEM_WB_give_o, if32.MEM_WB_data_o, if32.MEM_EX_get_o} !== {1'b1, 32'h55, 1'b0}) begin
                miscompares++; $display("FAIL stall[%0d]: got %b/%h/%b expected 1/00000055/0", k, if32.MEM_WB_give_o, if32.MEM_WB_data_o, if32.MEM_EX_get_o); end
            step();
        end
        if32.WB_MEM_get_i = 1;
        #1;
        vectors++; if (if32.MEM_EX_get_o !== 1'b1) begin miscompares++; $display("FAIL stall_release_get: got %b expected 1", if32.MEM_EX_get_o); end
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if ({if32.MEM_WB_give_o, if32.MEM_WB_data_o} !== {1'b1, 32'h66}) begin
            miscompares++; $display("FAIL stall_next: got %b/%h expected 1/00000066", if32.MEM_WB_give_o, if32.MEM_WB_data_o); end
        step();
        if32.WB_MEM_get_i = 0;
    endtask

    task automatic test_jal_auipc();
        offer32(mk(3'b000, OPC_JAL), 32'hDEAD, 32'h0, 32'h1000);
        step();
        vectors++; if (if32.MEM_WB_data_o !== 32'h1004) begin miscompares++; $display("FAIL jal_link: got %h expected 00001004", if32.MEM_WB_data_o); end
        if32.WB_MEM_get_i = 1;
        offer32(mk(3'b000, OPC_AUIPC), 32'h3000, 32'h0, 32'h2000);
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if (if32.MEM_WB_data_o !== 32'h3000) begin miscompares++; $display("FAIL auipc: got %h expected 00003000", if32.MEM_WB_data_o); end
        step();
        if32.WB_MEM_get_i = 0;
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_FAULT_EN
        offer32(mk(3'b010, OPC_LOAD), 32'h2, 32'h0, 32'h700);
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if ({if32.MEM_read_o, if32.MEM_write_o, if32.MEM_WB_give_o, if32.MEM_WB_fault_o} !== 4'b0011) begin
            miscompares++; $display("FAIL lw_mis_fault: got %b expected 0011", {if32.MEM_read_o, if32.MEM_write_o, if32.MEM_WB_give_o, if32.MEM_WB_fault_o}); end
        vectors++; if (if32.MEM_WB_data_o !== 32'h2) begin miscompares++; $display("FAIL lw_mis_data: got %h expected 00000002", if32.MEM_WB_data_o); end
        if32.WB_MEM_get_i = 1;
        offer32(mk(3'b011, OPC_LOAD), 32'h8, 32'h0, 32'h704);
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if ({if32.MEM_read_o, if32.MEM_WB_fault_o, if32.MEM_WB_data_o} !== {1'b0, 1'b1, 32'h8}) begin
            miscompares++; $display("FAIL ld32_illegal: got %b/%b/%h expected 0/1/00000008", if32.MEM_read_o, if32.MEM_WB_fault_o, if32.MEM_WB_data_o); end
        step();
        if32.WB_MEM_get_i = 0;
`else
        offer32(mk(3'b010, OPC_LOAD), 32'h2, 32'h0, 32'h700);
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if ({if32.MEM_read_o, if32.MEM_addr_o} !== {1'b1, 32'h0}) begin
            miscompares++; $display("FAIL lw_mis_forced: got %b/%h expected 1/00000000", if32.MEM_read_o, if32.MEM_addr_o); end
        if32.MEM_data_i = 32'hDEAD_BEEF; if32.MEM_valid_i = 1;
        step();
        if32.MEM_valid_i = 0;
        vectors++; if ({if32.MEM_WB_fault_o, if32.MEM_WB_data_o} !== {1'b0, 32'hDEAD_BEEF}) begin
            miscompares++; $display("FAIL lw_mis_data: got %b/%h expected 0/deadbeef", if32.MEM_WB_fault_o, if32.MEM_WB_data_o); end
        if32.WB_MEM_get_i = 1;
        offer32(mk(3'b011, OPC_LOAD), 32'h8, 32'h0, 32'h704);
        step();
        if32.EX_MEM_give_i = 0; if32.WB_MEM_get_i = 0;
        vectors++; if ({if32.MEM_read_o, if32.MEM_addr_o} !== {1'b1, 32'h8}) begin
            miscompares++; $display("FAIL ld32_as_word_req: got %b/%h expected 1/00000008", if32.MEM_read_o, if32.MEM_addr_o); end
        if32.MEM_data_i = 32'h8000_0000; if32.MEM_valid_i = 1;
        step();
        if32.MEM_valid_i = 0;
        vectors++; if ({if32.MEM_WB_fault_o, if32.MEM_WB_data_o} !== {1'b0, 32'h8000_0000}) begin
            miscompares++; $display("FAIL ld32_as_word: got %b/%h expected 0/80000000", if32.MEM_WB_fault_o, if32.MEM_WB_data_o); end
        if32.WB_MEM_get_i = 1;
        step();
        if32.WB_MEM_get_i = 0;
`endif
    endtask

    task automatic test_reset_in_req();
        offer32(mk(3'b010, OPC_LOAD), 32'h20, 32'h0, 32'h800);
        step();
        if32.EX_MEM_give_i = 0;
        vectors++; if (if32.MEM_read_o !== 1'b1) begin miscompares++; $display("FAIL rreq_read: got %b expected 1", if32.MEM_read_o); end
        resetn = 1'b0;
        step();
        vectors++; if ({if32.MEM_read_o, if32.MEM_WB_give_o} !== 2'b00) begin
            miscompares++; $display("FAIL rreq_drop: got %b expected 00", {if32.MEM_read_o, if32.MEM_WB_give_o}); end
        resetn = 1'b1;
        if32.MEM_data_i = 32'h1111_2222; if32.MEM_valid_i = 1;
        step();
        if32.MEM_valid_i = 0;
        vectors++; if ({if32.MEM_read_o, if32.MEM_WB_give_o, if32.MEM_EX_get_o} !== 3'b001) begin
            miscompares++; $display("FAIL rreq_late_valid: got %b expected 001", {if32.MEM_read_o, if32.MEM_WB_give_o, if32.MEM_EX_get_o}); end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_lh_lhu();
        test_xlen64();
        test_back_to_back();
        test_wb_stall();
        test_jal_auipc();
        test_misalign();
        test_reset_in_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/lsu_stage.md
# lsu_stage

Parametrised load/store pipeline stage between EX and WB; successor to the fixed 32-bit memory stage. Adds configurable data width (32/64), byte-lane strobes with lane-shifted store data, sub-word load extraction with sign/zero extension, and misalignment detection. A back-to-back hand-off path lets a non-memory instruction retire every cycle.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- BE_W, XLEN/8: byte-enable width (derived, not overridden).

- clk  in  1  clock; all state on rising edge.
- resetn_i  in  1  synchronous, active-low reset.
- EX_MEM_give_i  in  1  EX offers an instruction.
- MEM_EX_get_o  out  1  stage accepts; transfer when both high.
- EX_MEM_instr_i  in  32  instruction word.
- EX_MEM_result_i  in  XLEN  ALU result / effective address.
- EX_MEM_rs2_i  in  XLEN  store data.
- EX_MEM_pc_i  in  XLEN  instruction PC.
- MEM_addr_o  out  XLEN  byte address, low bits unmasked.
- MEM_data_o  out  XLEN  lane-aligned store data.
- MEM_be_o  out  BE_W  byte strobes.
- MEM_read_o / MEM_write_o  out  1  request strobes.
- MEM_data_i  in  XLEN  load data, full bus word.
- MEM_valid_i  in  1  memory completes the current request.
- WB_MEM_get_i  in  1  WB accepts.
- MEM_WB_give_o  out  1  result valid; transfer when both high.
- MEM_WB_instr_o  out  32  instruction.
- MEM_WB_data_o  out  XLEN  result.
- MEM_WB_fault_o  out  1  misaligned/illegal-size access.

## Operation
- States: IDLE, REQ, RESP. Reset -> IDLE; all outputs 0; internal registers cleared.
- IDLE: MEM_EX_get_o=1. On transfer: capture instr/address/rs2/pc; LOAD/STORE without fault -> REQ; otherwise -> RESP.
- Result select on capture: JAL/JALR -> pc+4; AUIPC -> result; LOAD/STORE -> pending; other -> result.
- Size = funct3[1:0]: 00 byte, 01 half, 10 word, 11 dword. Dword at XLEN=32 is illegal.
- off = addr[log2(BE_W)-1:0]. Store: MEM_be_o = ((1<<bytes)-1)<<off; MEM_data_o = rs2<<(8*off). Strobes 0 for loads.
- REQ: exactly one of MEM_read_o/MEM_write_o held high with stable addr/data/be until MEM_valid_i. On MEM_valid_i: load latches (MEM_data_i>>(8*off)) extended per funct3[2] (1=zero, 0=sign) to XLEN; store result 0. -> RESP.
- RESP: MEM_WB_give_o=1 with registered instr/data/fault. On WB transfer: MEM_EX_get_o=1 the same cycle; a simultaneous EX transfer is captured as from IDLE; else -> IDLE.
- Fault: request never issued; -> RESP with fault=1, data=address.
- Reset in REQ: strobes drop next edge; pending response is ignored.

## Timing
- Non-memory op accepted cycle N: MEM_WB_give_o high from N+1. Steady-state throughput 1/cycle with WB_MEM_get_i held high.
- Memory op accepted cycle N: request visible N+1; MEM_valid_i in cycle M (M>=N+1) -> MEM_WB_give_o from M+1. Minimum latency 2 cycles.
- MEM_WB_* outputs are registered and stable while give is high and not taken.
- MEM_EX_get_o is 0 throughout REQ.
- MEM_valid_i outside REQ is ignored.

## Configuration
- LSU_MISALIGN_FAULT_EN defined: misaligned access (addr not a multiple of size) or illegal size -> fault path above.
- Undefined: alignment is not checked; low address bits are forced to size alignment on MEM_addr_o and the lane shift. MEM_WB_fault_o tied 0, except illegal size, which is treated as word.

## Structure
- Package lsu_pkg: opcode constants (LOAD, STORE, JAL, JALR, AUIPC), size enum, state enum, funct3 field positions.
- Sub-module lsu_align: combinational; computes be, store-lane shift, load extract/extend and the misalignment flag from size, offset and XLEN.

## Test plan
- XLEN=32, SB rs2=0x1234_56AB to addr 0x103 -> be=4'b1000, data=0xAB00_0000, write held until valid, give 1 cycle after.
- XLEN=32, LH addr 0x102, MEM_data_i=0x8001_0000 -> WB data 0xFFFF_8001; LHU -> 0x0000_8001.
- XLEN=64, LD addr 0x8, data 0x0123_4567_89AB_CDEF -> full value; LW addr 0xC, data 0x8000_0000_xxxx_xxxx -> 0xFFFF_FFFF_8000_0000.
- ADD ops back-to-back, WB_MEM_get_i=1 -> one WB transfer per cycle; WB stalled 3 cycles -> outputs stable, MEM_EX_get_o=0.
- With LSU_MISALIGN_FAULT_EN, LW addr 0x2 -> no read strobe, fault=1, data=0x2, 1-cycle latency.
- resetn_i low during REQ with late MEM_valid_i -> strobes 0 next cycle, no WB give, IDLE.
